// File: rtl/seg7_pkg.sv
// Shared state encoding and active-high hex-to-segment table for the display scanner.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Segment order {g,f,e,d,c,b,a}; 1 = segment lit
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, running whenever rst is low.
module scan_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed N-digit seven-segment scanner with dead time between digits and a
// pending/shadow buffer pair so new values only appear at frame boundaries.
module seg7_scan_controller #(
  parameter int CLK_HZ       = 25000000,
  parameter int SCAN_HZ      = 1000,
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYC    = 16,
  parameter int COMMON_ANODE = 1,
  parameter int BLANK_ZEROS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [4*N_DIGITS-1:0]       i_value,
  input  logic [N_DIGITS-1:0]         i_dp,
  input  logic                        i_load,
  output logic                        o_ack,
  output logic [N_DIGITS-1:0]         o_an,
  output logic [6:0]                  o_seg,
  output logic                        o_dp,
  output logic [$clog2(N_DIGITS)-1:0] o_digit_idx
);
  import seg7_pkg::*;

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int IW  = $clog2(N_DIGITS);
  localparam int BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic          INV        = (COMMON_ANODE != 0);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blank_q, blank_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d, shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  ack_q, ack_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick, frame_wrap, commit;
  logic [N_DIGITS-1:0]   lit;

  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blank_d = blank_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          blank_d = '0;
        end
        ST_BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            blank_d = '0;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (tick) begin
            state_d = ST_BLANK;
            blank_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pending commits at a frame wrap, when the display is (or is being) disabled,
  // and always while idle; a same-cycle load stays pending for the next commit.
  assign frame_wrap = i_enable && (state_q == ST_DRIVE) && tick && (idx_q == IDX_LAST);
  assign commit     = pend_vld_q && (frame_wrap || !i_enable || (state_q == ST_IDLE));

  always_comb begin
    pend_val_d = i_load ? i_value : pend_val_q;
    pend_dp_d  = i_load ? i_dp : pend_dp_q;
    pend_vld_d = i_load | (pend_vld_q & ~commit);
    shad_val_d = commit ? pend_val_q : shad_val_q;
    shad_dp_d  = commit ? pend_dp_q : shad_dp_q;
    ack_d      = commit;
  end

  // Leading-zero mask, scanned from the most significant digit down
  always_comb begin
    logic seen;
    seen = 1'b0;
    lit  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen   = seen | (shad_val_d[4*i +: 4] != 4'h0) | shad_dp_d[i];
      lit[i] = seen || (i == 0) || (BLANK_ZEROS == 0);
    end
  end

  // Outputs are built from next-state values so they line up with state_q
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (state_d == ST_DRIVE && lit[idx_d]) begin
      an_d[idx_d] = 1'b1;
      seg_d       = hex2seg(shad_val_d[{idx_d, 2'b00} +: 4]);
      dp_d        = shad_dp_d[idx_d];
    end
    an_d  = an_d ^ {N_DIGITS{INV}};
    seg_d = seg_d ^ {7{INV}};
    dp_d  = dp_d ^ INV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      blank_q    <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      ack_q      <= 1'b0;
      an_q       <= {N_DIGITS{INV}};
      seg_q      <= {7{INV}};
      dp_q       <= INV;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      blank_q    <= blank_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      ack_q      <= ack_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_an        = an_q;
  assign o_seg       = seg_q;
  assign o_dp        = dp_q;
  assign o_digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for the 4-digit scanner at DIV=10, two blank cycles, common anode.
module tb_seg7_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic        i_load;
  logic        o_ack;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [1:0]  o_digit_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int ack0;
  int cnt;

  seg7_scan_controller #(
    .CLK_HZ(100), .SCAN_HZ(10), .N_DIGITS(4), .BLANK_CYC(2),
    .COMMON_ANODE(1), .BLANK_ZEROS(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_value     (i_value),
    .i_dp        (i_dp),
    .i_load      (i_load),
    .o_ack       (o_ack),
    .o_an        (o_an),
    .o_seg       (o_seg),
    .o_dp        (o_dp),
    .o_digit_idx (o_digit_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_ack === 1'b1) ack_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Active-low pin pattern expected for a hex digit on a common-anode display
  function automatic logic [6:0] seg_n(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return ~tbl[h];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bound_ok(input string tag, input int n, input int limit);
    n_assert++;
    assert (n < limit) else begin
      n_fail++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, limit);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    i_value = v;
    i_dp    = dp;
    i_load  = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
  endtask

  task automatic wait_lit(input int k);
    int n = 0;
    while (!(o_digit_idx == 2'(k) && o_an != 4'hF) && n < 200) begin
      @(negedge clk);
      n++;
    end
    bound_ok($sformatf("wait_lit%0d", k), n, 200);
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (o_digit_idx != 2'(k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    bound_ok($sformatf("wait_idx%0d", k), n, 200);
  endtask

  // Lit cycles seen while digit k is being scanned
  task automatic slot_lit(input int k, output int lit_n);
    int n = 0;
    lit_n = 0;
    while (o_digit_idx == 2'(k) && n < 50) begin
      if (o_an != 4'hF) lit_n++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_value = '0; i_dp = '0; i_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an",  32'(o_an),        32'hF);
    chk("rst_seg", 32'(o_seg),       32'h7F);
    chk("rst_dp",  32'(o_dp),        32'h1);
    chk("rst_ack", 32'(o_ack),       32'h0);
    chk("rst_idx", 32'(o_digit_idx), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Load in IDLE commits right away, then scan 1234
    load(16'h1234, 4'h0);
    repeat (3) @(negedge clk);
    chk("idle_ack", 32'(ack_cnt), 32'd1);
    chk("idle_dark", 32'(o_an), 32'hF);
    i_enable = 1'b1;
    wait_lit(0);
    chk("t1_an0",  32'(o_an),  32'hE);
    chk("t1_seg0", 32'(o_seg), 32'(seg_n(4'h4)));
    chk("t1_dp0",  32'(o_dp),  32'h1);
    wait_lit(1);
    chk("t1_an1",  32'(o_an),  32'hD);
    chk("t1_seg1", 32'(o_seg), 32'(seg_n(4'h3)));
    cnt = 0;
    while (o_an == 4'hD && cnt < 50) begin cnt++; @(negedge clk); end
    chk("t1_lit_len", 32'(cnt), 32'd8);
    cnt = 0;
    while (o_an == 4'hF && cnt < 50) begin cnt++; @(negedge clk); end
    chk("t1_dead", 32'(cnt), 32'd2);
    chk("t1_idx2", 32'(o_digit_idx), 32'd2);
    chk("t1_an2",  32'(o_an),  32'hB);
    chk("t1_seg2", 32'(o_seg), 32'(seg_n(4'h2)));
    wait_lit(3);
    chk("t1_an3",  32'(o_an),  32'h7);
    chk("t1_seg3", 32'(o_seg), 32'(seg_n(4'h1)));

    // Mid-frame load is held until the wrap
    wait_lit(1);
    ack0 = ack_cnt;
    load(16'h00A5, 4'h0);
    wait_lit(2);
    chk("t2_hold2", 32'(o_seg), 32'(seg_n(4'h2)));
    wait_lit(3);
    chk("t2_hold3", 32'(o_seg), 32'(seg_n(4'h1)));
    chk("t2_noack", 32'(ack_cnt), 32'(ack0));
    wait_lit(0);
    chk("t2_ack",  32'(ack_cnt), 32'(ack0 + 1));
    chk("t2_seg0", 32'(o_seg), 32'(seg_n(4'h5)));
    wait_lit(1);
    chk("t2_seg1", 32'(o_seg), 32'(seg_n(4'hA)));
    wait_idx(2);
    slot_lit(2, cnt);
    chk("t2_dark2", 32'(cnt), 32'd0);
    slot_lit(3, cnt);
    chk("t2_dark3", 32'(cnt), 32'd0);

    // Two loads in one frame: last wins, single ack
    wait_lit(0);
    ack0 = ack_cnt;
    load(16'h1111, 4'h0);
    repeat (2) @(negedge clk);
    load(16'h2222, 4'h0);
    wait_idx(1);
    wait_lit(0);
    chk("t3_seg0", 32'(o_seg), 32'(seg_n(4'h2)));
    chk("t3_ack",  32'(ack_cnt), 32'(ack0 + 1));
    wait_lit(3);
    chk("t3_seg3", 32'(o_seg), 32'(seg_n(4'h2)));

    // Load landing on the frame-boundary edge (8th lit cycle of digit 3)
    ack0 = ack_cnt;
    load(16'h5678, 4'h0);
    repeat (6) @(negedge clk);
    chk("t4_last_lit", 32'(o_an), 32'h7);
    load(16'h9ABC, 4'h0);
    chk("t4_blank", 32'(o_an), 32'hF);
    chk("t4_ack1",  32'(o_ack), 32'h1);
    wait_lit(0);
    chk("t4_seg0_x", 32'(o_seg), 32'(seg_n(4'h8)));
    wait_lit(3);
    chk("t4_seg3_x", 32'(o_seg), 32'(seg_n(4'h5)));
    wait_lit(0);
    chk("t4_seg0_y", 32'(o_seg), 32'(seg_n(4'hC)));
    chk("t4_ack2",   32'(ack_cnt), 32'(ack0 + 2));

    // Disable during digit 2, then re-enable
    wait_lit(2);
    repeat (2) @(negedge clk);
    ack0 = ack_cnt;
    i_enable = 1'b0;
    @(negedge clk);
    chk("t5_an_off", 32'(o_an), 32'hF);
    chk("t5_idx0",   32'(o_digit_idx), 32'd0);
    chk("t5_seg_off", 32'(o_seg), 32'h7F);
    chk("t5_noack",  32'(ack_cnt), 32'(ack0));
    i_enable = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (o_an == 4'hF && cnt < 50) begin cnt++; @(negedge clk); end
    chk("t5_dead",  32'(cnt), 32'd2);
    chk("t5_an0",   32'(o_an), 32'hE);
    chk("t5_idx",   32'(o_digit_idx), 32'd0);
    chk("t5_seg0",  32'(o_seg), 32'(seg_n(4'hC)));

    // Async reset mid-DRIVE with a pending value
    load(16'h0001, 4'h0);
    wait_lit(1);
    @(negedge clk);
    ack0 = ack_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_an",  32'(o_an),        32'hF);
    chk("t6_seg", 32'(o_seg),       32'h7F);
    chk("t6_dp",  32'(o_dp),        32'h1);
    chk("t6_ack", 32'(o_ack),       32'h0);
    chk("t6_idx", 32'(o_digit_idx), 32'd0);
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_pend_clr", 32'(ack_cnt), 32'(ack0));
    i_enable = 1'b1;
    wait_lit(0);
    chk("t6_shadow0", 32'(o_seg), 32'(seg_n(4'h0)));
    wait_idx(1);
    slot_lit(1, cnt);
    chk("t6_dark1", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
